// File: rtl/board_io_pkg.sv
// Shared helpers for the board I/O front end: debounce counter sizing and PWM constants.
// duty_t itself is declared per instance in the top, since it depends on the PWM_BITS parameter.
package board_io_pkg;

    localparam int DEF_PWM_BITS = 8;

    typedef logic [DEF_PWM_BITS-1:0] duty_def_t;

    // The counter only has to reach DEB_CYCLES-1, so $clog2 bits never wrap.
    function automatic int deb_cnt_w(input int deb_cycles);
        return (deb_cycles < 2) ? 1 : $clog2(deb_cycles);
    endfunction

    function automatic int pwm_period(input int pwm_bits);
        return 1 << pwm_bits;
    endfunction

    function automatic int pwm_max(input int pwm_bits);
        return (1 << pwm_bits) - 1;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One input channel: 2-FF synchroniser, stability counter, debounced level and edge pulses.
// Latency: pad step to level/edge pulse is 2+DEB_CYCLES cycles; no backpressure.
module io_debounce
    import board_io_pkg::*;
#(
    parameter int   DEB_CYCLES = 250000,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W   = deb_cnt_w(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= pad;
            sync2 <= sync1;
        end
    end

    // Any cycle where the synced value matches the level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_io_frontend.sv
// Board pin front end: debounced inputs with edge pulses, per-channel PWM LED drive, edge interrupts.
// Inputs: 2+DEB_CYCLES cycles to in_o; pwm_o registered, 1 cycle; no backpressure.
// Optional BOARD_IO_IRQ_EN builds pending/irq flops; otherwise irq outputs are tied low.
module board_io_frontend
    import board_io_pkg::*;
#(
    parameter int                NUM_IN     = 8,
    parameter int                DEB_CYCLES = 250000,
    parameter logic [NUM_IN-1:0] IN_RST_VAL = '0,
    parameter int                NUM_PWM    = 16,
    parameter int                PWM_BITS   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_IN-1:0]           pad_i,
    output logic [NUM_IN-1:0]           in_o,
    output logic [NUM_IN-1:0]           rise_o,
    output logic [NUM_IN-1:0]           fall_o,
    input  logic [NUM_PWM*PWM_BITS-1:0] duty_i,
    input  logic [NUM_PWM-1:0]          pwm_en_i,
    output logic [NUM_PWM-1:0]          pwm_o,
    input  logic [NUM_IN-1:0]           irq_mask_i,
    input  logic [NUM_IN-1:0]           irq_clr_i,
    output logic [NUM_IN-1:0]           irq_pend_o,
    output logic                        irq_o
);

    typedef logic [PWM_BITS-1:0] duty_t;

    localparam duty_t CNT_LAST = duty_t'(pwm_max(PWM_BITS));

    for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
        io_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_VAL    (IN_RST_VAL[i])
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .pad   (pad_i[i]),
            .level (in_o[i]),
            .rise  (rise_o[i]),
            .fall  (fall_o[i])
        );
    end

    duty_t cnt;
    duty_t duty_q   [NUM_PWM];
    duty_t duty_eff [NUM_PWM];
    logic  init_q;

    // The first cycle after reset uses duty_i directly, so the reset-time duty applies from cnt=0.
    always_comb begin
        for (int k = 0; k < NUM_PWM; k++) begin
            duty_eff[k] = init_q ? duty_i[k*PWM_BITS +: PWM_BITS] : duty_q[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            init_q <= 1'b1;
            pwm_o  <= '0;
            for (int k = 0; k < NUM_PWM; k++) begin
                duty_q[k] <= '0;
            end
        end else begin
            cnt    <= cnt + 1'b1;
            init_q <= 1'b0;
            for (int k = 0; k < NUM_PWM; k++) begin
                pwm_o[k] <= pwm_en_i[k] && (cnt < duty_eff[k]);
                // Duty only changes across the wrap, so a period is never cut short.
                if (init_q || cnt == CNT_LAST) begin
                    duty_q[k] <= duty_i[k*PWM_BITS +: PWM_BITS];
                end
            end
        end
    end

`ifdef BOARD_IO_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pend_o <= '0;
            irq_o      <= 1'b0;
        end else begin
            // Set has priority over a simultaneous clear.
            irq_pend_o <= (irq_pend_o & ~irq_clr_i) | rise_o | fall_o;
            irq_o      <= |(irq_pend_o & irq_mask_i);
        end
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_mask_i, irq_clr_i};
    assign irq_pend_o        = '0;
    assign irq_o             = 1'b0;
`endif

endmodule

// File: tb/tb_board_io_frontend.sv
// Scoreboarded bench for board_io_frontend: reference model pushes per-cycle expectations, monitor pops.
module tb_board_io_frontend;

    localparam int NI     = 8;
    localparam int DEB    = 4;
    localparam int NP     = 4;
    localparam int PB     = 4;
    localparam int PERIOD = 1 << PB;
    localparam logic [NI-1:0] RST_VAL = 8'h00;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI-1:0]    pad_i;
    logic [NI-1:0]    in_o, rise_o, fall_o;
    logic [NP*PB-1:0] duty_i;
    logic [NP-1:0]    pwm_en_i;
    logic [NP-1:0]    pwm_o;
    logic [NI-1:0]    irq_mask_i, irq_clr_i, irq_pend_o;
    logic             irq_o;

    board_io_frontend #(
        .NUM_IN(NI), .DEB_CYCLES(DEB), .IN_RST_VAL(RST_VAL), .NUM_PWM(NP), .PWM_BITS(PB)
    ) dut (
        .clk(clk), .rst(rst), .pad_i(pad_i), .in_o(in_o), .rise_o(rise_o), .fall_o(fall_o),
        .duty_i(duty_i), .pwm_en_i(pwm_en_i), .pwm_o(pwm_o),
        .irq_mask_i(irq_mask_i), .irq_clr_i(irq_clr_i), .irq_pend_o(irq_pend_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NI-1:0] in_v, rise_v, fall_v, pend_v;
        logic [NP-1:0] pwm_v;
        logic          irq_v;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a level is accepted once the pad, seen two cycles late through the
    // synchroniser, has disagreed with it for DEB consecutive cycles. PWM duty is captured
    // at each period boundary and the output is high for the first duty counts of the period.
    logic [NI-1:0] lvl_m, rise_m, fall_m, pend_m;
    logic [NI-1:0] pad_hist[$];
    int            run_m[NI];
    int            duty_m[NP];
    int            phase_m;
    bit            fresh_m;
    logic [NP-1:0] pwm_m;
    logic          irq_m;

    always @(posedge clk) begin
        exp_t          e;
        logic [NI-1:0] seen;
        int            dk;
        if (rst) begin
            lvl_m = RST_VAL; rise_m = '0; fall_m = '0; pend_m = '0; irq_m = 1'b0;
            pad_hist = '{RST_VAL, RST_VAL};
            for (int i = 0; i < NI; i++) run_m[i] = 0;
            for (int k = 0; k < NP; k++) duty_m[k] = 0;
            phase_m = 0; fresh_m = 1'b1; pwm_m = '0;
        end else begin
`ifdef BOARD_IO_IRQ_EN
            irq_m  = |(pend_m & irq_mask_i);
            pend_m = (pend_m & ~irq_clr_i) | rise_m | fall_m;
`endif
            seen = pad_hist.pop_front();
            pad_hist.push_back(pad_i);
            rise_m = '0; fall_m = '0;
            for (int i = 0; i < NI; i++) begin
                if (seen[i] != lvl_m[i]) begin
                    run_m[i]++;
                    if (run_m[i] == DEB) begin
                        lvl_m[i] = seen[i]; rise_m[i] = seen[i]; fall_m[i] = !seen[i]; run_m[i] = 0;
                    end
                end else begin
                    run_m[i] = 0;
                end
            end
            for (int k = 0; k < NP; k++) begin
                dk = fresh_m ? int'(duty_i[k*PB +: PB]) : duty_m[k];
                pwm_m[k] = pwm_en_i[k] && (phase_m < dk);
                if (fresh_m || phase_m == PERIOD - 1) duty_m[k] = int'(duty_i[k*PB +: PB]);
            end
            fresh_m = 1'b0;
            phase_m = (phase_m + 1) % PERIOD;
        end
        cyc++;
        e.in_v = lvl_m; e.rise_v = rise_m; e.fall_v = fall_m; e.pend_v = pend_m;
        e.pwm_v = pwm_m; e.irq_v = irq_m;
        exp_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("in_o",       in_o,       e.in_v);
            chk("rise_o",     rise_o,     e.rise_v);
            chk("fall_o",     fall_o,     e.fall_v);
            chk("pwm_o",      pwm_o,      e.pwm_v);
            chk("irq_pend_o", irq_pend_o, e.pend_v);
            chk("irq_o",      irq_o,      e.irq_v);
        end
    end

    // Returns cycles from now until the requested pulse on channel ch, or -1 after 30 cycles.
    task automatic wait_edge(input int ch, input bit want_rise, output int lat);
        int t0 = cyc;
        lat = -1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #2;
            if (want_rise ? rise_o[ch] : fall_o[ch]) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int ch, input int cycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #2;
            if (rise_o[ch] || fall_o[ch]) cnt++;
        end
    endtask

    task automatic count_high(input int ch, output int cnt);
        cnt = 0;
        for (int n = 0; n < PERIOD; n++) begin
            @(posedge clk); #2;
            if (pwm_o[ch]) cnt++;
        end
    endtask

    task automatic set_duty(input int ch, input int d);
        duty_i[ch*PB +: PB] = PB'(d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lat, cnt, noise;
        rst = 1'b1; pad_i = '0; duty_i = '0; pwm_en_i = '0; irq_mask_i = '0; irq_clr_i = '0;
        repeat (4) @(negedge clk);
        chk("reset_in_o",  in_o,  RST_VAL);
        chk("reset_pwm_o", pwm_o, 0);
        chk("reset_irq_o", irq_o, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean step on channel 0.
        pad_i[0] = 1'b1;
        wait_edge(0, 1'b1, lat);
        chk("ch0_rise_latency", lat, 6);
        count_pulses(0, 10, cnt);
        chk("ch0_single_pulse", cnt, 0);

        // Bouncing channel 1: one rise, six cycles after the final toggle.
        @(negedge clk); pad_i[1] = 1'b1;
        repeat (2) @(negedge clk); pad_i[1] = 1'b0;
        repeat (2) @(negedge clk); pad_i[1] = 1'b1;
        wait_edge(1, 1'b1, lat);
        chk("ch1_bounce_latency", lat, 6);
        count_pulses(1, 10, cnt);
        chk("ch1_single_pulse", cnt, 0);

        // PWM: duty 4, then 12 changed mid-period, then 0.
        @(negedge clk); set_duty(0, 4); pwm_en_i[0] = 1'b1;
        repeat (40) @(negedge clk);
        count_high(0, cnt);
        chk("pwm_duty4_high", cnt, 4);
        repeat (5) @(negedge clk); set_duty(0, 12);
        repeat (40) @(negedge clk);
        count_high(0, cnt);
        chk("pwm_duty12_high", cnt, 12);
        @(negedge clk); set_duty(0, 0);
        repeat (40) @(negedge clk);
        count_high(0, cnt);
        chk("pwm_duty0_high", cnt, 0);

        // Enable drop on channel 2 during its high phase.
        @(negedge clk); set_duty(2, 10); pwm_en_i[2] = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #2;
            if (pwm_o[2]) break;
        end
        chk("pwm2_high_seen", pwm_o[2], 1);
        @(negedge clk); pwm_en_i[2] = 1'b0;
        @(posedge clk); #2;
        chk("pwm2_en_drop", pwm_o[2], 0);

`ifdef BOARD_IO_IRQ_EN
        @(negedge clk); irq_mask_i = 8'h01; pad_i[0] = 1'b0;
        wait_edge(0, 1'b0, lat);
        repeat (2) begin @(posedge clk); #2; end
        chk("irq_after_edge", irq_o, 1);
        @(negedge clk); irq_clr_i[0] = 1'b1;
        @(negedge clk); irq_clr_i[0] = 1'b0; pad_i[0] = 1'b1;
        wait_edge(0, 1'b1, lat);
        @(negedge clk); irq_clr_i[0] = 1'b1;
        @(posedge clk); #2;
        chk("irq_set_wins", irq_pend_o[0], 1);
        @(negedge clk);
        @(posedge clk); #2;
        chk("irq_clear_pend", irq_pend_o[0], 0);
        @(negedge clk); irq_clr_i[0] = 1'b0;
        @(posedge clk); #2;
        chk("irq_clear_out", irq_o, 0);
`endif

        // Randomised traffic, with a reset dropped in half way through.
        for (int seg = 0; seg < 16; seg++) begin
            noise = (seg % 2 == 0) ? 2 + int'($urandom_range(0, 4)) : 12 + int'($urandom_range(0, 20));
            if (seg == 8) begin
                @(negedge clk); rst = 1'b1; #1;
                chk("midrun_reset_in_o",  in_o,  RST_VAL);
                chk("midrun_reset_pwm_o", pwm_o, 0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            for (int n = 0; n < 80; n++) begin
                @(negedge clk);
                for (int i = 0; i < NI; i++)
                    if ($urandom_range(0, noise) == 0) pad_i[i] = ~pad_i[i];
                if ($urandom_range(0, 15) == 0) set_duty(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, PERIOD - 1)));
                if ($urandom_range(0, 30) == 0) pwm_en_i = NP'($urandom);
                if ($urandom_range(0, 40) == 0) irq_mask_i = NI'($urandom);
                irq_clr_i = ($urandom_range(0, 6) == 0) ? NI'($urandom) : '0;
            end
        end

        irq_clr_i = '0;
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
